// File: rtl/operand_sequencer.sv
// operand_sequencer: serial operand loader and result return stage for the
// multi-cycle add/sub datapath. Collects a, b, c, d (plus mode) over a byte
// stream, pulses start, waits for the datapath's done edge or a timeout, and
// hands the result back over a valid/ready handshake.
module operand_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_mode,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic       mode,
  output logic       start,
  input  logic       done,
  input  logic [7:0] result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [7:0]       a_n, b_n, c_n, d_n;
  logic             mode_n;
  logic             start_n;
  logic             out_valid_n;
  logic [7:0]       out_data_n;
  logic             out_error_n;
  logic             busy_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             done_q;
  logic             done_edge;

  // Only a fresh low-to-high transition of done counts as completion.
  assign done_edge = done & ~done_q;
  assign cnt_inc   = cnt + CNT_ONE;

  // Operand bytes are accepted only while loading.
  assign in_ready = (state == S_LOAD);

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    a_n         = a;
    b_n         = b;
    c_n         = c;
    d_n         = d;
    mode_n      = mode;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_error_n = out_error;
    cnt_n       = cnt;

    unique case (state)
      S_LOAD: begin
        if (in_valid) begin
          unique case (idx)
            2'd0: begin
              a_n    = in_data;
              mode_n = in_mode;
            end
            2'd1: b_n = in_data;
            2'd2: c_n = in_data;
            2'd3: d_n = in_data;
          endcase
          if (idx == 2'd3) begin
            idx_n   = 2'd0;
            state_n = S_ISSUE;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end

      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end

      S_WAIT: begin
        cnt_n = cnt_inc;
        // A done edge takes priority over a timeout landing in the same cycle.
        if (done_edge) begin
          out_data_n  = result;
          out_error_n = 1'b0;
          out_valid_n = 1'b1;
          state_n     = S_OUTPUT;
        end else if (cnt_inc == CNT_LAST) begin
          out_data_n  = '0;
          out_error_n = 1'b1;
          out_valid_n = 1'b1;
          state_n     = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = S_LOAD;
        end
      end

      default: state_n = S_LOAD;
    endcase

    // start and busy are registered from the upcoming state so they line up
    // with the state they describe without any combinational output path.
    start_n = (state_n == S_ISSUE);
    busy_n  = !((state_n == S_LOAD) && (idx_n == 2'd0));
  end

  // State, operand and result registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_LOAD;
      idx       <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      mode      <= 1'b0;
      start     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_error <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      a         <= a_n;
      b         <= b_n;
      c         <= c_n;
      d         <= d_n;
      mode      <= mode_n;
      start     <= start_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_error <= out_error_n;
      busy      <= busy_n;
      cnt       <= cnt_n;
    end
  end

  // done history for edge detection, tracked in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed checks for operand_sequencer with TIMEOUT=8.
module tb_operand_sequencer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic [7:0] a, b, c, d;
  logic       mode;
  logic       start;
  logic       done;
  logic [7:0] result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_error;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  operand_sequencer #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .mode      (mode),
    .start     (start),
    .done      (done),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_error (out_error),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] data, input logic m);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = m;
    step();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_mode  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    done = 1'b0; result = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ops", {a, b}, 16'h0000);
    reset = 1'b0;

    // basic stream, mode 0
    send(8'h05, 1'b0);
    chk("s1_busy_after_a", busy, 1);
    send(8'h03, 1'b1);
    send(8'h02, 1'b1);
    send(8'h01, 1'b1);
    chk("s1_ab", {a, b}, 16'h0503);
    chk("s1_cd", {c, d}, 16'h0201);
    chk("s1_mode", mode, 0);
    chk("s1_start", start, 1);
    chk("s1_in_ready_issue", in_ready, 0);
    step();
    chk("s1_start_once", start, 0);
    step();
    step();
    done = 1'b1; result = 8'h0B;
    step();
    chk("s1_valid", out_valid, 1);
    chk("s1_data", out_data, 16'h000B);
    chk("s1_err", out_error, 0);
    done = 1'b0; result = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_hold", {7'd0, out_valid, out_data}, 16'h010B);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("s1_hs_valid", out_valid, 0);
    chk("s1_hs_in_ready", in_ready, 1);
    chk("s1_hs_busy", busy, 0);
    chk("s1_hs_data_kept", out_data, 16'h000B);

    // timeout: done already high, no edge
    done = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    chk("to_start", start, 1);
    for (int i = 0; i < 7; i++) step();
    chk("to_not_yet", out_valid, 0);
    step();
    chk("to_valid", out_valid, 1);
    chk("to_err", out_error, 1);
    chk("to_data", out_data, 16'h0000);
    done = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("to_hs", {in_ready, out_valid}, 16'h0002);

    // done edge on the final timeout cycle beats the timeout
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    for (int i = 0; i < 7; i++) step();
    chk("co_not_yet", out_valid, 0);
    done = 1'b1; result = 8'h5A;
    step();
    chk("co_valid", out_valid, 1);
    chk("co_err", out_error, 0);
    chk("co_data", out_data, 16'h005A);
    done = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // bubbles between bytes, mode taken from first byte only
    send(8'hA1, 1'b1);
    step();
    step();
    chk("bb_a", a, 16'h00A1);
    chk("bb_b_untouched", b, 16'h0002);
    chk("bb_loading", {in_ready, busy}, 16'h0003);
    send(8'hB2, 1'b0);
    step();
    send(8'hC3, 1'b0);
    send(8'hD4, 1'b0);
    chk("bb_ab", {a, b}, 16'hA1B2);
    chk("bb_cd", {c, d}, 16'hC3D4);
    chk("bb_mode", mode, 1);
    chk("bb_start", start, 1);
    step();
    done = 1'b1; result = 8'h77;
    step();
    chk("bb_data", out_data, 16'h0077);
    done = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset while waiting
    send(8'h9A, 1'b1); send(8'hBC, 1'b0); send(8'hDE, 1'b0); send(8'hF0, 1'b0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rw_ops", {a, d}, 16'h0000);
    chk("rw_mode", mode, 0);
    chk("rw_out", {7'd0, out_valid, out_data}, 16'h0000);
    chk("rw_ctl", {start, busy, in_ready}, 16'h0001);
    #1;
    reset = 1'b0;
    done = 1'b1; result = 8'h99;
    step();
    step();
    chk("rw_no_result", out_valid, 0);
    chk("rw_in_ready", in_ready, 1);
    done = 1'b0;
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
    chk("rw_reload", {a, d}, 16'h1040);
    chk("rw_start", start, 1);
    step();
    done = 1'b1; result = 8'h42;
    step();
    chk("rw_data", out_data, 16'h0042);
    done = 1'b0;

    // back-to-back with out_ready tied high
    out_ready = 1'b1;
    step();
    chk("bk_ready", in_ready, 1);
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0); send(8'h64, 1'b0);
    chk("bk1_start", start, 1);
    chk("bk1_in_ready_issue", in_ready, 0);
    step();
    chk("bk1_in_ready_wait", in_ready, 0);
    done = 1'b1; result = 8'h21;
    step();
    chk("bk1_out", {7'd0, out_valid, out_data}, 16'h0121);
    chk("bk1_in_ready_out", in_ready, 0);
    done = 1'b0;
    in_valid = 1'b1; in_data = 8'hEE; in_mode = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bk1_hs", {in_ready, out_valid}, 16'h0002);
    chk("bk1_no_byte_in_hs", {7'd0, busy, a}, 16'h0061);
    send(8'h71, 1'b0); send(8'h72, 1'b0); send(8'h73, 1'b0); send(8'h74, 1'b0);
    chk("bk2_start", start, 1);
    chk("bk2_ops", {a, d}, 16'h7174);
    step();
    done = 1'b1; result = 8'h43;
    step();
    chk("bk2_out", {7'd0, out_valid, out_data}, 16'h0143);
    done = 1'b0;
    step();
    chk("bk2_hs", {in_ready, out_valid}, 16'h0002);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
